// File: rtl/mio_pkg.sv
// Shared definitions for the MIO FIFO port: register offsets, status layout
// and the bus-responder state encoding.
package mio_pkg;

   localparam logic [1:0] REG_DATA   = 2'd0;
   localparam logic [1:0] REG_STATUS = 2'd1;

   localparam int ST_RX_EMPTY = 0;
   localparam int ST_RX_FULL  = 1;
   localparam int ST_TX_EMPTY = 2;
   localparam int ST_TX_FULL  = 3;
   localparam int ST_OVF      = 4;
   localparam int ST_UNF      = 5;
   localparam int ST_RX_CNT   = 8;
   localparam int ST_TX_CNT   = 16;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESP,
      S_DONE
   } mio_state_e;

   typedef struct packed {
      logic       rx_empty;
      logic       rx_full;
      logic       tx_empty;
      logic       tx_full;
      logic       ovf;
      logic       unf;
      logic [7:0] rx_count;
      logic [7:0] tx_count;
   } mio_status_t;

   function automatic logic [31:0] pack_status(input mio_status_t s);
      logic [31:0] w;
      w                 = '0;
      w[ST_RX_EMPTY]    = s.rx_empty;
      w[ST_RX_FULL]     = s.rx_full;
      w[ST_TX_EMPTY]    = s.tx_empty;
      w[ST_TX_FULL]     = s.tx_full;
      w[ST_OVF]         = s.ovf;
      w[ST_UNF]         = s.unf;
      w[ST_RX_CNT +: 8] = s.rx_count;
      w[ST_TX_CNT +: 8] = s.tx_count;
      return w;
   endfunction

endpackage

// File: rtl/mio_fifo_port_if.sv
// CPU-side MIO bus: request/qualifiers from the CPU, data and ready strobe back.
interface mio_fifo_port_if;

   logic        CPU_MIO;
   logic        mem_w;
   logic [31:0] addr_bus;
   logic [31:0] Cpu_data2bus;
   logic [31:0] Cpu_data4bus;
   logic        MIO_ready;

   modport master (
      output CPU_MIO, mem_w, addr_bus, Cpu_data2bus,
      input  Cpu_data4bus, MIO_ready
   );

   modport slave (
      input  CPU_MIO, mem_w, addr_bus, Cpu_data2bus,
      output Cpu_data4bus, MIO_ready
   );

endinterface

// File: rtl/mio_fifo_port_sync_fifo.sv
// Single-clock FIFO; a push into a full FIFO is accepted when a pop happens
// in the same cycle.
module sync_fifo #(
   parameter int WIDTH      = 32,
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic [WIDTH-1:0]      din,
   input  logic                  pop,
   output logic [WIDTH-1:0]      dout,
   output logic                  full,
   output logic                  empty,
   output logic [DEPTH_LOG2:0]   count
);

   localparam int                DEPTH     = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

   logic [WIDTH-1:0]      mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr;
   logic [DEPTH_LOG2-1:0] rd_ptr;
   logic                  do_push;
   logic                  do_pop;

   assign empty   = (count == '0);
   assign full    = (count == DEPTH_CNT);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/mio_fifo_port.sv
// MIO-bus responder bridging CPU reads/writes to a TX and an RX stream FIFO,
// with programmable wait states before the one-cycle MIO_ready strobe.
module mio_fifo_port
   import mio_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR  = 32'hD000_0000,
   parameter int          DEPTH_LOG2 = 4,
   parameter int          WAIT_CYC   = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   mio_fifo_port_if.slave       bus,
   output logic                 tx_valid,
   output logic [31:0]          tx_data,
   input  logic                 tx_ready,
   input  logic                 rx_valid,
   input  logic [31:0]          rx_data,
   output logic                 rx_ready,
   output logic                 irq
);

   localparam logic [3:0] W_LAST = (WAIT_CYC == 0) ? 4'd0 : 4'(WAIT_CYC - 1);

   mio_state_e  state;
   logic [3:0]  wcnt;
   logic        lat_we;
   logic [1:0]  lat_reg;
   logic [31:0] lat_wdata;
   logic        rd_ok;
   logic        ovf;
   logic        unf;
   logic        mio_ready_q;
   logic [31:0] rdata_q;

   logic                tx_push, tx_pop, tx_full, tx_empty;
   logic                rx_push, rx_pop, rx_full, rx_empty;
   logic [DEPTH_LOG2:0] tx_count, rx_count;
   logic [31:0]         rx_head;

   logic        hit, accept, enter_resp, in_resp, cur_we;
   logic [1:0]  cur_reg;
   logic [31:0] rdata_next;
   mio_status_t st;

   sync_fifo #(.WIDTH(32), .DEPTH_LOG2(DEPTH_LOG2)) u_tx (
      .clk   (clk),
      .rst   (rst),
      .push  (tx_push),
      .din   (lat_wdata),
      .pop   (tx_pop),
      .dout  (tx_data),
      .full  (tx_full),
      .empty (tx_empty),
      .count (tx_count)
   );

   sync_fifo #(.WIDTH(32), .DEPTH_LOG2(DEPTH_LOG2)) u_rx (
      .clk   (clk),
      .rst   (rst),
      .push  (rx_push),
      .din   (rx_data),
      .pop   (rx_pop),
      .dout  (rx_head),
      .full  (rx_full),
      .empty (rx_empty),
      .count (rx_count)
   );

   assign tx_valid = ~tx_empty;
   assign rx_ready = ~rx_full;
   assign tx_pop   = tx_valid & tx_ready;
   assign rx_push  = rx_valid & rx_ready;
   assign irq      = ~rx_empty | ovf | unf;

   assign bus.MIO_ready    = mio_ready_q;
   assign bus.Cpu_data4bus = rdata_q;

   always_comb begin
      hit        = (bus.addr_bus[31:4] == BASE_ADDR[31:4]);
      accept     = (state == S_IDLE) && bus.CPU_MIO && hit;
      enter_resp = (accept && (WAIT_CYC == 0)) ||
                   ((state == S_WAIT) && bus.CPU_MIO && (wcnt == W_LAST));
      in_resp    = (state == S_RESP);
      // With zero wait states the response is built straight off the bus.
      cur_we     = (state == S_IDLE) ? bus.mem_w         : lat_we;
      cur_reg    = (state == S_IDLE) ? bus.addr_bus[3:2] : lat_reg;

      st.rx_empty = rx_empty;
      st.rx_full  = rx_full;
      st.tx_empty = tx_empty;
      st.tx_full  = tx_full;
      st.ovf      = ovf;
      st.unf      = unf;
      st.rx_count = 8'(rx_count);
      st.tx_count = 8'(tx_count);

      rdata_next = '0;
      if (!cur_we && cur_reg == REG_DATA)
         rdata_next = rx_empty ? '0 : rx_head;
      else if (!cur_we && cur_reg == REG_STATUS)
         rdata_next = pack_status(st);

      tx_push = in_resp && lat_we && (lat_reg == REG_DATA);
      // Pop only if the head was captured into the response register.
      rx_pop  = in_resp && !lat_we && (lat_reg == REG_DATA) && rd_ok;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         wcnt        <= '0;
         lat_we      <= 1'b0;
         lat_reg     <= '0;
         lat_wdata   <= '0;
         rd_ok       <= 1'b0;
         mio_ready_q <= 1'b0;
         rdata_q     <= '0;
      end else begin
         mio_ready_q <= enter_resp;
         rdata_q     <= enter_resp ? rdata_next : '0;
         if (enter_resp) rd_ok <= ~rx_empty;
         case (state)
            S_IDLE: begin
               if (accept) begin
                  lat_we    <= bus.mem_w;
                  lat_reg   <= bus.addr_bus[3:2];
                  lat_wdata <= bus.Cpu_data2bus;
                  wcnt      <= '0;
                  state     <= (WAIT_CYC == 0) ? S_RESP : S_WAIT;
               end
            end
            S_WAIT: begin
               if (!bus.CPU_MIO)        state <= S_IDLE;
               else if (wcnt == W_LAST) state <= S_RESP;
               else                     wcnt  <= wcnt + 4'd1;
            end
            S_RESP:  state <= S_DONE;
            S_DONE:  if (!bus.CPU_MIO) state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ovf <= 1'b0;
         unf <= 1'b0;
      end else begin
         if (tx_push && tx_full && !tx_pop)
            ovf <= 1'b1;
         if (in_resp && !lat_we && (lat_reg == REG_DATA) && !rd_ok)
            unf <= 1'b1;
         if (in_resp && lat_we && (lat_reg == REG_STATUS)) begin
            if (lat_wdata[ST_OVF]) ovf <= 1'b0;
            if (lat_wdata[ST_UNF]) unf <= 1'b0;
         end
      end
   end

endmodule
